hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core; drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the EX-stage forwarding muxes.
- Resolves load-use hazards, branch/jump redirects and variable-latency data-memory waits.
- Holds the front end in a fixed warm-up window after reset.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- BOOT_HOLD, 2, cycles after reset release during which fetch is held and the decode and execute stages are flushed (range 1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- rs1D, rs2D  in  5 each  source registers of the instruction in ID.
- rs1E, rs2E, rdE  in  5 each  source and destination registers of the instruction in EX.
- rdM, rdW  in  5 each  destination registers of the instructions in MEM and WB.
- regwenM, regwenW  in  1 each  register-write enable of the MEM and WB instructions.
- memreadE  in  1  the EX instruction is a load.
- redirectE  in  1  a taken branch or jump has resolved in EX.
- mem_reqM  in  1  the MEM instruction accesses data memory.
- mem_ackM  in  1  data memory completes the access this cycle.
- stallF, stallD, stallE, stallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- flushD, flushE, flushW  out  1 each  insert a bubble into IF/ID, ID/EX and MEM/WB.
- fwdAE, fwdBE  out  2 each  EX operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- FSM states: BOOT, RUN, MEM_WAIT. The FSM, the boot counter and the perf counters are registered.
- Reset, while i_rst is high:
  - state = BOOT, boot counter = 0, stall_cnt = flush_cnt = 0.
  - Outputs: stallF = 1, flushD = 1, flushE = 1; all other stall/flush outputs 0; fwdAE = fwdBE = 00.
- BOOT:
  - Outputs are the same as in reset.
  - The boot counter increments each cycle; move to RUN on the edge where counter == BOOT_HOLD-1.
  - Result: exactly BOOT_HOLD held cycles after reset release. Boot cycles are not counted.
- RUN, evaluated combinationally in this priority order:
  1. mem_reqM && !mem_ackM:
     - stallF = stallD = stallE = stallM = 1, flushW = 1.
     - Enter MEM_WAIT next cycle. redirectE and load-use are ignored this cycle.
  2. redirectE:
     - flushD = 1, flushE = 1.
     - Any load-use stall is suppressed, because the dependent instruction is squashed.
  3. Load-use, memreadE && rdE != 0 && (rdE == rs1D || rdE == rs2D):
     - stallF = 1, stallD = 1, flushE = 1 for one cycle.
     - This is a single-cycle rule; no extra state is needed, since the load advances and the condition clears.
  4. Otherwise all stall/flush outputs are 0.
- MEM_WAIT:
  - Outputs are the same as in priority case 1 for as long as !mem_ackM.
  - On mem_ackM: release all stalls that same cycle, return to RUN, and apply redirect/load-use rules to that cycle's inputs.
  - A redirectE held during the wait therefore fires in the ack cycle.
- Forwarding, combinational and valid in every state:
  - fwdAE = 10 if regwenM && rdM != 0 && rdM == rs1E.
  - Otherwise fwdAE = 01 if regwenW && rdW != 0 && rdW == rs1E.
  - Otherwise fwdAE = 00.
  - fwdBE is identical using rs2E.
  - MEM has priority over WB. x0 is never forwarded.
- Counters:
  - stall_cnt increments in every RUN/MEM_WAIT cycle with stallF = 1.
  - flush_cnt increments in every RUN/MEM_WAIT cycle with flushD | flushE.
  - Both saturate at all-ones; no wrap.
- Simultaneous events:
  - mem_ackM and a new mem_reqM in the same cycle: ack wins that cycle; the next access is re-evaluated on the next cycle.
  - i_rst asserted mid-wait or mid-boot: immediate asynchronous return to BOOT with counters cleared.

Decomposition:
- Shared package (core_pkg): fwd_sel_e enum (FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10), hz_state_e enum (BOOT, RUN, MEM_WAIT), REG_ADDR_W = 5.
- One natural sub-module, fwd_unit: the purely combinational forwarding compare, instantiated once and producing both selects.
- FSM, boot counter and perf counters stay in hazard_ctrl.

Test Plan:
- Reset release, BOOT_HOLD = 2 -> stallF = flushD = flushE = 1 for exactly 2 cycles, then all 0; stall_cnt = 0.
- Load-use: memreadE = 1, rdE = 5, rs1D = 5 -> one cycle of stallF = stallD = flushE = 1. With rdE = 0 -> no stall.
- Forwarding: rdM = rdW = 7, both regwen = 1, rs1E = 7 -> fwdAE = 10. With regwenM = 0 -> 01. With rdM = rdW = 0 -> 00.
- Memory wait: mem_reqM = 1, ack after 3 cycles -> stallF/D/E/M and flushW high for 3 cycles, released in the ack cycle; stall_cnt = 3.
- redirectE asserted during MEM_WAIT and held -> no flush while waiting; flushD = flushE = 1 exactly in the ack cycle; flush_cnt = 1.
- redirectE and load-use in the same cycle -> flushD = flushE = 1, stallF = 0. i_rst pulsed mid-MEM_WAIT -> outputs return to BOOT values asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the core pipeline control logic: forwarding selects,
// hazard-controller states and register address width.
package core_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        MEM_WAIT
    } hz_state_e;

    // MEM has priority over WB because it holds the younger result; x0 is hardwired zero.
    function automatic fwd_sel_e fwd_pick(
        input logic                  regwen_m,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  regwen_w,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic [REG_ADDR_W-1:0] rs
    );
        if (regwen_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (regwen_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational EX-stage forwarding compare producing both operand selects.
module fwd_unit
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1E,
    input  logic [REG_ADDR_W-1:0] rs2E,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  regwenM,
    input  logic                  regwenW,
    output fwd_sel_e              fwdAE,
    output fwd_sel_e              fwdBE
);

    always_comb begin
        fwdAE = fwd_pick(regwenM, rdM, regwenW, rdW, rs1E);
        fwdBE = fwd_pick(regwenM, rdM, regwenW, rdW, rs2E);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline controller: boot hold, load-use / redirect / memory-wait
// stall and flush generation, EX forwarding and saturating perf counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int BOOT_HOLD = 2,
    parameter int CNT_W     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rs1E,
    input  logic [REG_ADDR_W-1:0] rs2E,
    input  logic [REG_ADDR_W-1:0] rdE,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  regwenM,
    input  logic                  regwenW,
    input  logic                  memreadE,
    input  logic                  redirectE,
    input  logic                  mem_reqM,
    input  logic                  mem_ackM,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  stallM,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  flushW,
    output logic [1:0]            fwdAE,
    output logic [1:0]            fwdBE,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_HOLD - 1);

    hz_state_e        state_q, state_d;
    logic [3:0]       boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    fwd_sel_e         fwd_a, fwd_b;
    logic             load_use;

    fwd_unit u_fwd (
        .rs1E    (rs1E),
        .rs2E    (rs2E),
        .rdM     (rdM),
        .rdW     (rdW),
        .regwenM (regwenM),
        .regwenW (regwenW),
        .fwdAE   (fwd_a),
        .fwdBE   (fwd_b)
    );

    assign fwdAE     = fwd_a;
    assign fwdBE     = fwd_b;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign load_use  = memreadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushW     = 1'b0;

        unique case (state_q)
            BOOT: begin
                stallF     = 1'b1;
                flushD     = 1'b1;
                flushE     = 1'b1;
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN, MEM_WAIT: begin
                // In MEM_WAIT only the ack matters; an ack releases the pipe and
                // the normal redirect/load-use rules apply to that same cycle.
                if ((state_q == RUN) ? (mem_reqM && !mem_ackM) : !mem_ackM) begin
                    stallF  = 1'b1;
                    stallD  = 1'b1;
                    stallE  = 1'b1;
                    stallM  = 1'b1;
                    flushW  = 1'b1;
                    state_d = MEM_WAIT;
                end else begin
                    state_d = RUN;
                    if (redirectE) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (load_use) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != BOOT) begin
            if (stallF && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if ((flushD || flushE) && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= BOOT;
            boot_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl using a queue of expected
// per-cycle outputs and a small model of the perf counters.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        regwenM, regwenW, memreadE, redirectE, mem_reqM, mem_ackM;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]  fwdAE, fwdBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        string      tag;
        logic [6:0] flags;
        logic [3:0] fwd;
        logic       boot;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    // Flag order: {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    localparam logic [6:0] F_NONE  = 7'b000_0000;
    localparam logic [6:0] F_BOOT  = 7'b100_0110;
    localparam logic [6:0] F_LU    = 7'b110_0010;
    localparam logic [6:0] F_MEM   = 7'b111_1001;
    localparam logic [6:0] F_REDIR = 7'b000_0110;

    hazard_ctrl #(.BOOT_HOLD(2), .CNT_W(CNT_W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .rs1E      (rs1E),
        .rs2E      (rs2E),
        .rdE       (rdE),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwenM   (regwenM),
        .regwenW   (regwenW),
        .memreadE  (memreadE),
        .redirectE (redirectE),
        .mem_reqM  (mem_reqM),
        .mem_ackM  (mem_ackM),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .stallM    (stallM),
        .flushD    (flushD),
        .flushE    (flushE),
        .flushW    (flushW),
        .fwdAE     (fwdAE),
        .fwdBE     (fwdBE),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [6:0] flagsNow();
        return {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
    endfunction

    task automatic clearInputs();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {regwenM, regwenW, memreadE, redirectE, mem_reqM, mem_ackM} = '0;
    endtask

    // Queue the expectation for the current cycle, check it mid-cycle, then advance.
    task automatic applyStimulus(input string tag, input logic [6:0] flags,
                                 input logic [3:0] fwd, input logic boot);
        exp_t e, got;
        e.tag = tag; e.flags = flags; e.fwd = fwd; e.boot = boot;
        sb.push_back(e);
        @(negedge i_clk);
        got = sb.pop_front();
        checkOutput({got.tag, "_flags"}, {25'd0, flagsNow()}, {25'd0, got.flags});
        checkOutput({got.tag, "_fwd"}, {28'd0, fwdAE, fwdBE}, {28'd0, got.fwd});
        @(posedge i_clk);
        #1;
        if (!got.boot) begin
            if (got.flags[6] && m_stall != '1) m_stall = m_stall + 1'b1;
            if ((got.flags[2] || got.flags[1]) && m_flush != '1) m_flush = m_flush + 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_stall_cnt"}, stall_cnt, m_stall);
        checkOutput({tag, "_flush_cnt"}, flush_cnt, m_flush);
    endtask

    initial begin
        clearInputs();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("reset_flags", {25'd0, flagsNow()}, {25'd0, F_BOOT});
        checkOutput("reset_fwd", {28'd0, fwdAE, fwdBE}, 32'd0);
        checkCounters("reset");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        applyStimulus("boot0", F_BOOT, 4'b0000, 1'b1);
        applyStimulus("boot1", F_BOOT, 4'b0000, 1'b1);
        applyStimulus("run_idle", F_NONE, 4'b0000, 1'b0);
        checkCounters("after_boot");

        memreadE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
        applyStimulus("load_use_rs1", F_LU, 4'b0000, 1'b0);
        memreadE = 1'b0;
        applyStimulus("load_use_clear", F_NONE, 4'b0000, 1'b0);
        memreadE = 1'b1; rdE = 5'd0; rs1D = 5'd0;
        applyStimulus("load_use_x0", F_NONE, 4'b0000, 1'b0);
        rdE = 5'd9; rs1D = 5'd3; rs2D = 5'd9;
        applyStimulus("load_use_rs2", F_LU, 4'b0000, 1'b0);
        clearInputs();
        checkCounters("after_load_use");

        rdM = 5'd7; rdW = 5'd7; regwenM = 1'b1; regwenW = 1'b1; rs1E = 5'd7; rs2E = 5'd7;
        applyStimulus("fwd_mem_pri", F_NONE, 4'b1010, 1'b0);
        regwenM = 1'b0;
        applyStimulus("fwd_wb", F_NONE, 4'b0101, 1'b0);
        rdM = 5'd0; rdW = 5'd0; regwenM = 1'b1; rs1E = 5'd0; rs2E = 5'd0;
        applyStimulus("fwd_x0", F_NONE, 4'b0000, 1'b0);
        rdM = 5'd7; rdW = 5'd3; rs1E = 5'd7; rs2E = 5'd3;
        applyStimulus("fwd_split", F_NONE, 4'b1001, 1'b0);
        clearInputs();

        mem_reqM = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("mem_wait", F_MEM, 4'b0000, 1'b0);
        mem_ackM = 1'b1;
        applyStimulus("mem_ack", F_NONE, 4'b0000, 1'b0);
        clearInputs();
        applyStimulus("mem_after", F_NONE, 4'b0000, 1'b0);
        checkCounters("after_mem_wait");

        mem_reqM = 1'b1; redirectE = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("redir_wait", F_MEM, 4'b0000, 1'b0);
        mem_ackM = 1'b1;
        applyStimulus("redir_ack", F_REDIR, 4'b0000, 1'b0);
        clearInputs();
        checkCounters("after_redir_wait");

        redirectE = 1'b1; memreadE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
        applyStimulus("redir_over_lu", F_REDIR, 4'b0000, 1'b0);
        clearInputs();

        mem_reqM = 1'b1; mem_ackM = 1'b1;
        applyStimulus("req_ack_run", F_NONE, 4'b0000, 1'b0);
        mem_ackM = 1'b0;
        applyStimulus("req_wait", F_MEM, 4'b0000, 1'b0);
        mem_ackM = 1'b1;
        applyStimulus("ack_with_req", F_NONE, 4'b0000, 1'b0);
        mem_ackM = 1'b0;
        applyStimulus("req_reeval", F_MEM, 4'b0000, 1'b0);
        mem_ackM = 1'b1; memreadE = 1'b1; rdE = 5'd4; rs2D = 5'd4;
        applyStimulus("ack_load_use", F_LU, 4'b0000, 1'b0);
        clearInputs();
        checkCounters("after_back_to_back");

        mem_reqM = 1'b1;
        applyStimulus("pre_reset_wait", F_MEM, 4'b0000, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("async_reset_flags", {25'd0, flagsNow()}, {25'd0, F_BOOT});
        m_stall = '0;
        m_flush = '0;
        checkCounters("async_reset");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        clearInputs();
        applyStimulus("reboot0", F_BOOT, 4'b0000, 1'b1);
        applyStimulus("reboot1", F_BOOT, 4'b0000, 1'b1);
        applyStimulus("rerun_idle", F_NONE, 4'b0000, 1'b0);
        checkCounters("after_reboot");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
